// File: rtl/color_scan_ctrl.sv
// color_scan_ctrl: steps the colour-sensor filter through red/green/blue/clear, counts sensor edges per window, publishes counts + dominant colour.
// Latency: 4*(SETTLE_CYCLES+WINDOW_CYCLES+1)+1 clk from the edge that samples start (or cont_mode) to the done pulse.
// Backpressure: none; start is ignored while busy, published results are simply replaced by the next scan.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   start               single-cycle scan request (ignored while busy)
//   cont_mode           back-to-back scanning while high
//   sensor_out          raw sensor frequency output, asynchronous to clk
//   s2, s3              photodiode filter select: red 00, green 11, blue 01, clear 10
//   busy, done          scan in progress / one-cycle publish strobe
//   *_cnt, color        published per-channel edge counts and dominant colour (00 none, 01 red, 10 green, 11 blue)

module color_scan_ctrl #(
    parameter int SETTLE_CYCLES = 1000,
    parameter int WINDOW_CYCLES = 50000,
    parameter int CNT_W         = 16,
    parameter int BLACK_THRESH  = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont_mode,
    input  logic             sensor_out,
    output logic             s2,
    output logic             s3,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] blue_cnt,
    output logic [CNT_W-1:0] clear_cnt,
    output logic [1:0]       color
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_STORE,
        ST_PUBLISH
    } state_t;

    // Channel index doubles as scan order.
    typedef enum logic [1:0] {
        CH_RED   = 2'd0,
        CH_GREEN = 2'd1,
        CH_BLUE  = 2'd2,
        CH_CLEAR = 2'd3
    } chan_t;

    typedef struct packed {
        logic [CNT_W-1:0] red;
        logic [CNT_W-1:0] green;
        logic [CNT_W-1:0] blue;
        logic [CNT_W-1:0] clear;
    } chan_cnts_t;

    // One timer serves both the settle and the measurement phases.
    localparam int TMAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] WINDOW_LAST = TW'(WINDOW_CYCLES - 1);
    localparam logic [63:0]   THRESH64    = 64'(BLACK_THRESH);

    state_t           state_q;
    chan_t            chan_q;
    logic [TW-1:0]    timer_q;
    logic [CNT_W-1:0] edge_cnt_q;
    chan_cnts_t       sh_q;
    chan_cnts_t       pub_q;
    logic             sync1_q;
    logic             sync2_q;
    logic             sync3_q;
    logic             edge_det;
    logic [1:0]       color_nxt;

    function automatic logic [1:0] filt_code(input chan_t ch);
        logic [1:0] code;
        case (ch)
            CH_RED:   code = 2'b00;
            CH_GREEN: code = 2'b11;
            CH_BLUE:  code = 2'b01;
            default:  code = 2'b10;
        endcase
        return code;
    endfunction

    // sync1/sync2 resolve metastability; sync3 is the one-cycle-old copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= sensor_out;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign edge_det = sync2_q & ~sync3_q;

    // Dominant colour from the completed shadow set; ties go red > green > blue.
    always_comb begin
        color_nxt = 2'b01;
        if (64'(sh_q.clear) < THRESH64) begin
            color_nxt = 2'b00;
        end else if ((sh_q.red >= sh_q.green) && (sh_q.red >= sh_q.blue)) begin
            color_nxt = 2'b01;
        end else if (sh_q.green >= sh_q.blue) begin
            color_nxt = 2'b10;
        end else begin
            color_nxt = 2'b11;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            chan_q     <= CH_RED;
            timer_q    <= '0;
            edge_cnt_q <= '0;
            sh_q       <= '0;
            pub_q      <= '0;
            color      <= 2'b00;
            s2         <= 1'b0;
            s3         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // busy is still high in the done cycle, so a request there waits one cycle.
                    if (!busy && (start || cont_mode)) begin
                        state_q    <= ST_SETTLE;
                        chan_q     <= CH_RED;
                        {s2, s3}   <= filt_code(CH_RED);
                        timer_q    <= '0;
                        edge_cnt_q <= '0;
                        busy       <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end

                ST_SETTLE: begin
                    if (timer_q == SETTLE_LAST) begin
                        state_q <= ST_MEASURE;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                ST_MEASURE: begin
                    // Saturating count: a very fast sensor pins at all-ones rather than wrapping.
                    if (edge_det && (edge_cnt_q != '1)) begin
                        edge_cnt_q <= edge_cnt_q + 1'b1;
                    end
                    if (timer_q == WINDOW_LAST) begin
                        state_q <= ST_STORE;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                ST_STORE: begin
                    case (chan_q)
                        CH_RED:   sh_q.red   <= edge_cnt_q;
                        CH_GREEN: sh_q.green <= edge_cnt_q;
                        CH_BLUE:  sh_q.blue  <= edge_cnt_q;
                        default:  sh_q.clear <= edge_cnt_q;
                    endcase
                    if (chan_q == CH_CLEAR) begin
                        state_q <= ST_PUBLISH;
                    end else begin
                        state_q    <= ST_SETTLE;
                        chan_q     <= chan_t'(chan_q + 2'd1);
                        {s2, s3}   <= filt_code(chan_t'(chan_q + 2'd1));
                        edge_cnt_q <= '0;
                    end
                end

                ST_PUBLISH: begin
                    // Results become visible together with done, one cycle after this state.
                    pub_q      <= sh_q;
                    color      <= color_nxt;
                    done       <= 1'b1;
                    chan_q     <= CH_RED;
                    {s2, s3}   <= filt_code(CH_RED);
                    timer_q    <= '0;
                    edge_cnt_q <= '0;
                    if (cont_mode) begin
                        state_q <= ST_SETTLE;
                    end else begin
                        // busy stays high through the done cycle and drops from IDLE.
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign red_cnt   = pub_q.red;
    assign green_cnt = pub_q.green;
    assign blue_cnt  = pub_q.blue;
    assign clear_cnt = pub_q.clear;

endmodule

// File: tb/tb_color_scan_ctrl.sv
// tb_color_scan_ctrl: directed bench for color_scan_ctrl with a short settle/window configuration.
// Latency: scan completes SCAN_LAT edges after the sampling edge.
// Backpressure: n/a; sensor stimulus follows the DUT filter code.

module tb_color_scan_ctrl;

    localparam int SETTLE   = 4;
    localparam int WINDOW   = 100;
    localparam int SCAN_LAT = 4 * (SETTLE + WINDOW + 1) + 1;   // 421

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        cont_mode;
    logic        sensor_out;
    logic        s2;
    logic        s3;
    logic        busy;
    logic        done;
    logic [15:0] red_cnt;
    logic [15:0] green_cnt;
    logic [15:0] blue_cnt;
    logic [15:0] clear_cnt;
    logic [1:0]  color;

    logic        start_sat;
    logic        cont_sat;
    logic        sensor_sat;
    logic        s2_sat;
    logic        s3_sat;
    logic        busy_sat;
    logic        done_sat;
    logic [3:0]  red_sat;
    logic [3:0]  green_sat;
    logic [3:0]  blue_sat;
    logic [3:0]  clear_sat;
    logic [1:0]  color_sat;

    int errors = 0;
    int checks = 0;

    // Sensor generator control: 0 off, 1 fixed half-period, 2 half-period chosen by {s2,s3}.
    int gen_mode   = 0;
    int fixed_half = 5;
    int ch_half [4];

    logic [7:0]  codes_seen;
    logic        busy_dropped;
    logic        pub_changed;

    color_scan_ctrl #(
        .SETTLE_CYCLES(SETTLE),
        .WINDOW_CYCLES(WINDOW),
        .CNT_W(16),
        .BLACK_THRESH(20)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .cont_mode(cont_mode),
        .sensor_out(sensor_out),
        .s2(s2),
        .s3(s3),
        .busy(busy),
        .done(done),
        .red_cnt(red_cnt),
        .green_cnt(green_cnt),
        .blue_cnt(blue_cnt),
        .clear_cnt(clear_cnt),
        .color(color)
    );

    color_scan_ctrl #(
        .SETTLE_CYCLES(SETTLE),
        .WINDOW_CYCLES(WINDOW),
        .CNT_W(4),
        .BLACK_THRESH(20)
    ) dut_sat (
        .clk(clk),
        .rst_n(rst_n),
        .start(start_sat),
        .cont_mode(cont_sat),
        .sensor_out(sensor_sat),
        .s2(s2_sat),
        .s3(s3_sat),
        .busy(busy_sat),
        .done(done_sat),
        .red_cnt(red_sat),
        .green_cnt(green_sat),
        .blue_cnt(blue_sat),
        .clear_cnt(clear_sat),
        .color(color_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        int h;
        int last_h;
        int ph;
        sensor_out = 1'b0;
        last_h     = 0;
        ph         = 0;
        forever begin
            @(negedge clk);
            if (gen_mode == 1)      h = fixed_half;
            else if (gen_mode == 2) h = ch_half[{s2, s3}];
            else                    h = 0;
            if (h != last_h) begin
                ph     = 0;
                last_h = h;
            end
            if (h == 0) begin
                sensor_out = 1'b0;
            end else begin
                ph++;
                if (ph >= h) begin
                    ph         = 0;
                    sensor_out = ~sensor_out;
                end
            end
        end
    end

    // Toggles every 2 clk: 25 rising edges per 100-cycle window.
    initial begin
        int ph;
        sensor_sat = 1'b0;
        ph         = 0;
        forever begin
            @(negedge clk);
            ph++;
            if (ph >= 2) begin
                ph         = 0;
                sensor_sat = ~sensor_sat;
            end
        end
    end

    // Half-periods indexed by filter code: red 00, blue 01, clear 10, green 11.
    task automatic set_channels(input int r, input int g, input int b, input int c);
        ch_half[0] = r;
        ch_half[3] = g;
        ch_half[1] = b;
        ch_half[2] = c;
        gen_mode   = 2;
    endtask

    // Waits at negedges for done; k_done is the number of negedges waited, -1 on timeout.
    // A start pulse can be injected at negedge pulse_at (0 = none).
    task automatic wait_done(input int limit, input int pulse_at, output int k_done);
        logic [63:0] entry;
        k_done       = -1;
        busy_dropped = 1'b0;
        pub_changed  = 1'b0;
        codes_seen   = '0;
        entry        = {red_cnt, green_cnt, blue_cnt, clear_cnt};
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == pulse_at) start = 1'b1;
            if (k == 2)   codes_seen[7:6] = {s2, s3};
            if (k == 107) codes_seen[5:4] = {s2, s3};
            if (k == 212) codes_seen[3:2] = {s2, s3};
            if (k == 317) codes_seen[1:0] = {s2, s3};
            if (!busy) busy_dropped = 1'b1;
            if (done) begin
                k_done = k;
                break;
            end
            if ({red_cnt, green_cnt, blue_cnt, clear_cnt} != entry) pub_changed = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        cont_mode = 1'b0;
        start_sat = 1'b0;
        cont_sat  = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({s2, s3, busy, done} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl: s2 s3 busy done = %b want 0000", {s2, s3, busy, done}); end
        checks++; if ({red_cnt, green_cnt, blue_cnt, clear_cnt} !== 64'd0) begin errors++; $display("FAIL reset_counts: got %h want 0", {red_cnt, green_cnt, blue_cnt, clear_cnt}); end
        checks++; if (color !== 2'b00) begin errors++; $display("FAIL reset_color: got %b want 00", color); end
        checks++; if ({busy_sat, done_sat, red_sat, clear_sat} !== 10'd0) begin errors++; $display("FAIL reset_sat: got %h want 0", {busy_sat, done_sat, red_sat, clear_sat}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    // Period-10 square wave on every channel; a start mid-scan must not restart it.
    task automatic test_uniform();
        int k;
        gen_mode   = 1;
        fixed_half = 5;
        @(negedge clk);
        start = 1'b1;
        wait_done(SCAN_LAT + 50, 50, k);
        // +1: the first negedge waited follows the edge that samples start.
        checks++; if (k !== SCAN_LAT + 1) begin errors++; $display("FAIL uniform_latency: got %0d want %0d", k, SCAN_LAT + 1); end
        checks++; if (codes_seen !== 8'b00_11_01_10) begin errors++; $display("FAIL filter_sequence: got %b want 00110110", codes_seen); end
        checks++; if (busy_dropped !== 1'b0) begin errors++; $display("FAIL uniform_busy_hold: busy dropped during scan"); end
        checks++; if (pub_changed !== 1'b0) begin errors++; $display("FAIL uniform_partial: outputs changed before done"); end
        checks++; if ($isunknown(red_cnt) || red_cnt < 9 || red_cnt > 11) begin errors++; $display("FAIL uniform_red: got %0d want 9..11", red_cnt); end
        checks++; if ($isunknown(green_cnt) || green_cnt < 9 || green_cnt > 11) begin errors++; $display("FAIL uniform_green: got %0d want 9..11", green_cnt); end
        checks++; if ($isunknown(blue_cnt) || blue_cnt < 9 || blue_cnt > 11) begin errors++; $display("FAIL uniform_blue: got %0d want 9..11", blue_cnt); end
        checks++; if ($isunknown(clear_cnt) || clear_cnt < 9 || clear_cnt > 11) begin errors++; $display("FAIL uniform_clear: got %0d want 9..11", clear_cnt); end
        // clear ~10 is below the black threshold of 20.
        checks++; if (color !== 2'b00) begin errors++; $display("FAIL uniform_color: got %b want 00", color); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_done: got %b want 1", busy); end
        @(negedge clk);
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL busy_after_done: busy done = %b want 00", {busy, done}); end
    endtask

    // Distinct period per filter; a start during PUBLISH must be ignored.
    task automatic test_per_channel();
        int k;
        logic act;
        set_channels(10, 5, 20, 2);
        @(negedge clk);
        start = 1'b1;
        wait_done(SCAN_LAT + 50, SCAN_LAT, k);
        checks++; if (k !== SCAN_LAT + 1) begin errors++; $display("FAIL chan_latency: got %0d want %0d", k, SCAN_LAT + 1); end
        checks++; if ($isunknown(red_cnt) || red_cnt < 4 || red_cnt > 6) begin errors++; $display("FAIL chan_red: got %0d want 4..6", red_cnt); end
        checks++; if ($isunknown(green_cnt) || green_cnt < 9 || green_cnt > 11) begin errors++; $display("FAIL chan_green: got %0d want 9..11", green_cnt); end
        checks++; if ($isunknown(blue_cnt) || blue_cnt < 2 || blue_cnt > 3) begin errors++; $display("FAIL chan_blue: got %0d want 2..3", blue_cnt); end
        checks++; if ($isunknown(clear_cnt) || clear_cnt < 24 || clear_cnt > 26) begin errors++; $display("FAIL chan_clear: got %0d want 24..26", clear_cnt); end
        checks++; if (color !== 2'b10) begin errors++; $display("FAIL chan_color: got %b want 10", color); end
        start = 1'b0;
        act   = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done || (busy && !act)) act = 1'b1;
            act = act | done;
        end
        // The done-cycle busy was sampled before this loop, so any busy/done here is a new scan.
        checks++; if (act !== 1'b0) begin errors++; $display("FAIL publish_start_ignored: activity=%b want 0", act); end
    endtask

    task automatic test_ties_and_black();
        int k;
        set_channels(5, 5, 5, 2);
        @(negedge clk);
        start = 1'b1;
        wait_done(SCAN_LAT + 50, 0, k);
        checks++; if (color !== 2'b01) begin errors++; $display("FAIL tie_rgb_color: got %b want 01", color); end
        repeat (2) @(negedge clk);
        set_channels(10, 5, 5, 2);
        start = 1'b1;
        wait_done(SCAN_LAT + 50, 0, k);
        checks++; if (color !== 2'b10) begin errors++; $display("FAIL tie_gb_color: got %b want 10", color); end
        repeat (2) @(negedge clk);
        set_channels(2, 5, 5, 20);
        start = 1'b1;
        wait_done(SCAN_LAT + 50, 0, k);
        checks++; if ($isunknown(red_cnt) || red_cnt < 24 || red_cnt > 26) begin errors++; $display("FAIL black_red: got %0d want 24..26", red_cnt); end
        checks++; if ($isunknown(clear_cnt) || clear_cnt < 2 || clear_cnt > 3) begin errors++; $display("FAIL black_clear: got %0d want 2..3", clear_cnt); end
        checks++; if (color !== 2'b00) begin errors++; $display("FAIL black_color: got %b want 00", color); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_saturate();
        int k;
        k = -1;
        @(negedge clk);
        start_sat = 1'b1;
        for (int i = 1; i <= SCAN_LAT + 50; i++) begin
            @(negedge clk);
            start_sat = 1'b0;
            if (done_sat) begin
                k = i;
                break;
            end
        end
        checks++; if (k !== SCAN_LAT + 1) begin errors++; $display("FAIL sat_latency: got %0d want %0d", k, SCAN_LAT + 1); end
        checks++; if ({red_sat, green_sat, blue_sat, clear_sat} !== 16'hFFFF) begin errors++; $display("FAIL sat_counts: got %h want ffff", {red_sat, green_sat, blue_sat, clear_sat}); end
        checks++; if (color_sat !== 2'b00) begin errors++; $display("FAIL sat_color: got %b want 00", color_sat); end
    endtask

    task automatic test_cont_mode();
        int k;
        int n_done;
        logic busy_hi;
        gen_mode   = 1;
        fixed_half = 5;
        @(negedge clk);
        cont_mode = 1'b1;
        wait_done(SCAN_LAT + 50, 0, k);
        checks++; if (k !== SCAN_LAT + 1) begin errors++; $display("FAIL cont_first: got %0d want %0d", k, SCAN_LAT + 1); end
        for (int i = 0; i < 2; i++) begin
            wait_done(SCAN_LAT + 50, 0, k);
            checks++; if (k !== SCAN_LAT) begin errors++; $display("FAIL cont_period: got %0d want %0d", k, SCAN_LAT); end
            checks++; if (busy_dropped !== 1'b0) begin errors++; $display("FAIL cont_busy: busy dropped between scans"); end
        end
        checks++; if (red_cnt !== 16'd10) begin errors++; $display("FAIL cont_red: got %0d want 10", red_cnt); end
        repeat (100) @(negedge clk);
        cont_mode = 1'b0;
        wait_done(SCAN_LAT + 50, 0, k);
        checks++; if (k !== SCAN_LAT - 100) begin errors++; $display("FAIL cont_last_done: got %0d want %0d", k, SCAN_LAT - 100); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cont_last_busy: got %b want 1", busy); end
        n_done  = 0;
        busy_hi = 1'b0;
        repeat (SCAN_LAT + 30) begin
            @(negedge clk);
            if (done) n_done++;
            if (busy) busy_hi = 1'b1;
        end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL cont_extra_done: got %0d want 0", n_done); end
        checks++; if (busy_hi !== 1'b0) begin errors++; $display("FAIL cont_idle_busy: got %b want 0", busy_hi); end
    endtask

    task automatic test_reset_mid_scan();
        int k;
        set_channels(10, 5, 20, 2);
        @(negedge clk);
        start = 1'b1;
        repeat (250) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++; if ({s2, s3, busy} !== 3'b011) begin errors++; $display("FAIL pre_reset_blue: s2 s3 busy = %b want 011", {s2, s3, busy}); end
        rst_n = 1'b0;
        #1;
        checks++; if ({s2, s3, busy, done} !== 4'b0000) begin errors++; $display("FAIL midreset_ctrl: s2 s3 busy done = %b want 0000", {s2, s3, busy, done}); end
        checks++; if ({red_cnt, green_cnt, blue_cnt, clear_cnt, color} !== 66'd0) begin errors++; $display("FAIL midreset_outputs: got %h want 0", {red_cnt, green_cnt, blue_cnt, clear_cnt, color}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL midreset_no_publish: busy done = %b want 00", {busy, done}); end
        start = 1'b1;
        wait_done(SCAN_LAT + 50, 0, k);
        checks++; if (k !== SCAN_LAT + 1) begin errors++; $display("FAIL rescan_latency: got %0d want %0d", k, SCAN_LAT + 1); end
        checks++; if ($isunknown(clear_cnt) || clear_cnt < 24 || clear_cnt > 26) begin errors++; $display("FAIL rescan_clear: got %0d want 24..26", clear_cnt); end
        checks++; if (color !== 2'b10) begin errors++; $display("FAIL rescan_color: got %b want 10", color); end
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_per_channel();
        test_ties_and_black();
        test_saturate();
        test_cont_mode();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
